// File: rtl/axi_rid_tagger.sv
// Read-ID tagger: records the ARID of every accepted read burst in an external ID FIFO
// and re-attaches those IDs, in order, to the ID-less in-order read data from the DDR port.
module axi_rid_tagger #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 28,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_WIDTH = 256,
  parameter int OUTS_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [LEN_WIDTH-1:0]  s_arlen,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [LEN_WIDTH-1:0]  m_arlen,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] d_rdata,
  input  logic                  d_rlast,
  input  logic                  d_rvalid,
  output logic                  d_rready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  fifo_wr_en,
  output logic [ID_WIDTH-1:0]   fifo_wr_data,
  input  logic                  fifo_full,
  output logic                  fifo_rd_en,
  input  logic [ID_WIDTH-1:0]   fifo_rd_data,
  input  logic                  fifo_empty,
  output logic [OUTS_WIDTH-1:0] outstanding,
  output logic                  err_orphan
);

  typedef enum logic [1:0] {ST_EMPTY, ST_REQ, ST_VALID} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   cur_id_q;
  logic [OUTS_WIDTH-1:0] outs_q, outs_d;
  logic                  err_q, err_d;
  logic                  ar_hs, id_valid, r_last_hs;

  // AR side: a burst is only accepted when its ID has somewhere to go.
  assign s_arready    = m_arready & ~fifo_full;
  assign m_arvalid    = s_arvalid & ~fifo_full;
  assign m_araddr     = s_araddr;
  assign m_arlen      = s_arlen;
  assign ar_hs        = s_arvalid & s_arready;
  assign fifo_wr_en   = ar_hs;
  assign fifo_wr_data = s_arid;

  assign id_valid  = (state_q == ST_VALID);
  assign d_rready  = s_rready & id_valid;
  assign s_rvalid  = d_rvalid & id_valid;
  assign s_rdata   = d_rdata;
  assign s_rlast   = d_rlast;
  assign s_rid     = cur_id_q;
  assign r_last_hs = d_rvalid & d_rready & d_rlast;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (!fifo_empty) state_d = ST_REQ;
      ST_REQ:   state_d = ST_VALID;
      ST_VALID: if (r_last_hs) state_d = fifo_empty ? ST_EMPTY : ST_REQ;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // The pop is issued one cycle before the ID is captured; REQ is the capture cycle.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_EMPTY: fifo_rd_en = ~fifo_empty;
        ST_VALID: fifo_rd_en = r_last_hs & ~fifo_empty;
        default:  fifo_rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    cur_id_q <= '0;
    else if (state_q == ST_REQ) cur_id_q <= fifo_rd_data;
  end

  always_comb begin
    case ({ar_hs, r_last_hs})
      2'b10:   outs_d = outs_q + OUTS_WIDTH'(1);
      2'b01:   outs_d = outs_q - OUTS_WIDTH'(1);
      default: outs_d = outs_q;
    endcase
    err_d = err_q | (d_rvalid & (outs_q == '0) & ~ar_hs);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outs_q <= '0;
      err_q  <= 1'b0;
    end else begin
      outs_q <= outs_d;
      err_q  <= err_d;
    end
  end

  assign outstanding = outs_q;
  assign err_orphan  = err_q;

endmodule

// File: tb/tb_axi_rid_tagger.sv
// Directed bench for axi_rid_tagger with a small ID FIFO stand-in and a cycle-level
// reference model of ID ordering, load latency, outstanding count and orphan flag.
module tb_axi_rid_tagger;
  localparam int IDW = 4, AW = 28, LW = 8, DW = 256, OW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IDW-1:0] s_arid = '0;
  logic [AW-1:0] s_araddr = '0;
  logic [LW-1:0] s_arlen = '0;
  logic          s_arvalid = 1'b0, s_arready;
  logic [AW-1:0] m_araddr;
  logic [LW-1:0] m_arlen;
  logic          m_arvalid, m_arready = 1'b0;
  logic [DW-1:0] d_rdata = '0;
  logic          d_rlast = 1'b0, d_rvalid = 1'b0, d_rready;
  logic [IDW-1:0] s_rid;
  logic [DW-1:0] s_rdata;
  logic          s_rlast, s_rvalid, s_rready = 1'b1;
  logic          fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
  logic [IDW-1:0] fifo_wr_data, fifo_rd_data;
  logic [OW-1:0] outstanding;
  logic          err_orphan;

  axi_rid_tagger #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW),
                   .OUTS_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
    .d_rready(d_rready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .outstanding(outstanding),
    .err_orphan(err_orphan));

  always #5 clk = ~clk;

  // ID FIFO stand-in: 16 deep, read data registered one cycle after the pop.
  logic [IDW-1:0] fmem [16];
  logic [3:0]     fwp = '0, frp = '0;
  logic [4:0]     fcnt = '0;
  logic           force_full = 1'b0;
  assign fifo_empty = (fcnt == 5'd0);
  assign fifo_full  = force_full | (fcnt == 5'd16);
  always @(posedge clk) begin
    if (rst) begin
      fwp <= '0; frp <= '0; fcnt <= '0; fifo_rd_data <= '0;
    end else begin
      if (fifo_wr_en) begin fmem[fwp] <= fifo_wr_data; fwp <= fwp + 4'd1; end
      if (fifo_rd_en) begin fifo_rd_data <= fmem[frp]; frp <= frp + 4'd1; end
      fcnt <= fcnt + {4'b0, fifo_wr_en} - {4'b0, fifo_rd_en};
    end
  end

  int n_assert = 0, n_fail = 0;
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: IDs queue up in AR order; once a pop is issued the ID is usable two
  // edges later; each completed burst releases its ID and may start the next pop.
  logic [IDW-1:0] mq[$];
  logic [IDW-1:0] rid_log[$];
  logic [IDW-1:0] beat_rid[$];
  int             hs_cyc[$];
  logic [IDW-1:0] m_cur_id = '0, m_pend = '0;
  logic           m_cur_valid = 1'b0, m_fetch = 1'b0, m_err = 1'b0;
  int             m_outs = 0, cyc = 0;
  logic           mon_en = 1'b0;

  always @(negedge clk) begin
    logic e_arrdy, e_wr, e_drdy, last_hs, start;
    cyc++;
    if (mon_en) begin
      e_arrdy = m_arready & ~fifo_full;
      e_wr    = s_arvalid & e_arrdy;
      e_drdy  = s_rready & m_cur_valid;
      last_hs = d_rvalid & e_drdy & d_rlast;
      start   = !rst && (mq.size() != 0) &&
                ((!m_cur_valid && !m_fetch) || (m_cur_valid && last_hs));
      chk("s_arready", s_arready, e_arrdy);
      chk("m_arvalid", m_arvalid, s_arvalid & ~fifo_full);
      chk("fifo_wr_en", fifo_wr_en, e_wr);
      if (e_wr) chk("fifo_wr_data", fifo_wr_data, s_arid);
      chk("m_araddr", m_araddr, s_araddr);
      chk("m_arlen", m_arlen, s_arlen);
      chk("d_rready", d_rready, e_drdy);
      chk("s_rvalid", s_rvalid, d_rvalid & m_cur_valid);
      chk("s_rdata", s_rdata, d_rdata);
      chk("s_rlast", s_rlast, d_rlast);
      if (m_cur_valid) chk("s_rid", s_rid, m_cur_id);
      chk("fifo_rd_en", fifo_rd_en, start);
      chk("outstanding", outstanding, OW'(m_outs));
      chk("err_orphan", err_orphan, m_err);
      if (s_rvalid && s_rready) begin
        beat_rid.push_back(s_rid);
        if (s_rlast) begin rid_log.push_back(s_rid); hs_cyc.push_back(cyc); end
      end
      if (rst) begin
        mq.delete(); m_cur_valid = 0; m_fetch = 0; m_cur_id = '0; m_outs = 0; m_err = 0;
      end else begin
        m_err = m_err | (d_rvalid & (m_outs == 0) & ~e_wr);
        m_outs = m_outs + int'(e_wr) - int'(last_hs);
        if (m_fetch) begin m_cur_valid = 1; m_cur_id = m_pend; m_fetch = 0; end
        else if (last_hs) m_cur_valid = 0;
        if (start) begin m_pend = mq.pop_front(); m_fetch = 1; end
        if (e_wr) mq.push_back(s_arid);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ar(input logic [IDW-1:0] id, input logic [LW-1:0] len);
    s_arid = id; s_araddr = AW'($urandom); s_arlen = len; s_arvalid = 1; m_arready = 1;
    tick();
    s_arvalid = 0;
  endtask

  // Presents the current beat until it is accepted, bounded by a cycle budget.
  task automatic wait_hs();
    logic hs;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk); hs = d_rready;
      tick();
      if (hs) return;
    end
    chk("beat_timeout", 1'b1, 1'b0);
  endtask

  task automatic beats(input int n, input int stall_at, input logic [IDW-1:0] stall_id);
    for (int i = 0; i < n; i++) begin
      d_rvalid = 1; d_rlast = (i == n - 1); d_rdata = {8{$urandom}};
      if (i == stall_at) begin
        s_rready = 0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_d_rready", d_rready, 1'b0);
          chk("stall_rd_en", fifo_rd_en, 1'b0);
          chk("stall_rid", s_rid, stall_id);
          tick();
        end
        s_rready = 1;
      end
      wait_hs();
    end
    d_rvalid = 0; d_rlast = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    mon_en = 1;
    tick();
    rst = 0;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_orphan, 0);
    chk("rst_rvalid", s_rvalid, 0);

    // Single 4-beat burst with ID 3
    ar(4'd3, 8'd3);
    chk("t1_outs_after_ar", outstanding, 1);
    beats(4, -1, 4'd0);
    chk("t1_outs_after", outstanding, 0);
    chk("t1_beats", beat_rid.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_beat_rid", beat_rid[i], 4'd3);
    chk("t1_err", err_orphan, 0);

    // Back-to-back IDs 1,2,5 with single-beat bursts
    ar(4'd1, 8'd0); ar(4'd2, 8'd0); ar(4'd5, 8'd0);
    chk("t2_outs", outstanding, 3);
    beats(1, -1, 4'd0); beats(1, -1, 4'd0); beats(1, -1, 4'd0);
    chk("t2_log_size", rid_log.size(), 4);
    chk("t2_rid0", rid_log[1], 4'd1);
    chk("t2_rid1", rid_log[2], 4'd2);
    chk("t2_rid2", rid_log[3], 4'd5);
    chk("t2_gap0", hs_cyc[2] - hs_cyc[1], 2);
    chk("t2_gap1", hs_cyc[3] - hs_cyc[2], 2);

    // ID FIFO full blocks the AR channel
    force_full = 1; s_arvalid = 1; s_arid = 4'd7; s_arlen = 8'd0; m_arready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_arready", s_arready, 0);
      chk("t3_m_arvalid", m_arvalid, 0);
      chk("t3_wr_en", fifo_wr_en, 0);
      tick();
    end
    force_full = 0;
    @(negedge clk);
    chk("t3_arready_release", s_arready, 1);
    tick();
    s_arvalid = 0;
    beats(1, -1, 4'd0);
    chk("t3_rid", rid_log[4], 4'd7);

    // R-channel backpressure mid-burst
    ar(4'd9, 8'd3);
    beats(4, 2, 4'd9);
    chk("t4_rid", rid_log[5], 4'd9);
    chk("t4_outs", outstanding, 0);

    // Orphan beat with nothing outstanding
    d_rvalid = 1;
    @(negedge clk);
    chk("t5_rvalid", s_rvalid, 0);
    tick();
    d_rvalid = 0;
    chk("t5_err", err_orphan, 1);
    repeat (3) tick();
    chk("t5_err_sticky", err_orphan, 1);

    // Reset during the second beat of a 4-beat burst
    ar(4'd4, 8'd3);
    d_rvalid = 1; d_rlast = 0;
    wait_hs();
    rst = 1;
    tick();
    rst = 0;
    chk("t6_outs", outstanding, 0);
    chk("t6_rvalid", s_rvalid, 0);
    chk("t6_drready", d_rready, 0);
    chk("t6_err", err_orphan, 0);
    tick();
    d_rvalid = 0;
    repeat (3) tick();
    chk("t6_rvalid_later", s_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
